matmul_controller: RTL
======================

# matmul_controller

Sequencer that computes C = A × B over the coprocessor's three-matrix register file (A, B and C, each size×size cells of cell_width bits). It sits between the coprocessor's command logic and the register file, and is the only master of the register file's port while a multiply runs. It issues row reads of A, column reads of B and cell writes of C, and accumulates each dot product through a multiply-accumulate sub-unit.

## Interface
- size, 4: matrix dimension k.
- address_width, $clog2(size*size): register-file cell address width.
- cell_width, 32: bits per cell.
- width, cell_width*size: register-file data bus width.

Ports:
- in_clk  input  1  clock, rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_start  input  1  start request; sampled only in IDLE.
- out_busy  output  1  high from the cycle after start acceptance until the DONE cycle inclusive.
- out_done  output  1  one-cycle pulse when C is complete.
- out_rf_address  output  address_width  register-file address.
- out_rf_type  output  2  00 = cell, 01 = row, 10 = column.
- out_rf_select_matrix  output  2  00 = A, 01 = B, 10 = C.
- out_rf_read_en  output  1  register-file read enable.
- out_rf_write_en  output  1  register-file write enable.
- out_rf_data  output  width  write data. The result is in bits [cell_width-1:0]; all other bits are 0.
- in_rf_data  input  width  register-file read data. It is valid in the cycle after a read is sampled.

## Operation
- States: IDLE, READ_ROW, LATCH_ROW, READ_COL, LATCH_COL, MAC, WRITE, DONE.
- All register-file outputs are Moore decodes of the state and the i/j counters.
- IDLE
  - All enables are 0.
  - If in_start = 1, clear i, j and the accumulator, then go to READ_ROW.
- READ_ROW: read_en = 1, type = 01, select = 00, address = i*size.
- LATCH_ROW: capture in_rf_data into the row buffer.
- READ_COL: read_en = 1, type = 10, select = 01, address = j.
- LATCH_COL: capture in_rf_data into the column buffer, and clear the accumulator.
- MAC
  - Lasts exactly size cycles.
  - Cycle n adds row[n]*col[n] to the accumulator.
- WRITE
  - write_en = 1, type = 00, select = 10, address = i*size + j.
  - out_rf_data carries the accumulator.
  - Next state:
    - j < size-1: j++, go to READ_COL.
    - j = size-1 and i < size-1: j = 0, i++, go to READ_ROW.
    - otherwise: go to DONE.
- DONE: out_done = 1, then go to IDLE.
- The row of A is read once per i and reused for every j.
- Arithmetic is unsigned.
  - Each product and each sum is truncated to cell_width bits, i.e. modulo 2^cell_width.
  - There is no saturation and no overflow flag.
- in_start is ignored in every state other than IDLE, including DONE.
- read_en and write_en are never asserted in the same cycle.
- The controller never drives select = 11 or type = 11.
- Reset (in_reset = 0, at any time)
  - The state machine goes to IDLE immediately; i, j, the accumulator and the buffers are cleared.
  - Every output goes to 0: out_busy, out_done, out_rf_address, out_rf_type, out_rf_select_matrix, out_rf_read_en, out_rf_write_en, out_rf_data.
  - Cells of C already written stay written; the register file is not cleared by this block.

## Timing
- Let cycle 0 be the IDLE cycle in which in_start is sampled high.
- READ_ROW occupies cycle 1.
- Cycles per cell: 2 (column read and latch) + size (MAC) + 1 (WRITE).
- Cycles per row: 2 (row read and latch) + size*(size+3).
- N = size*(2 + size*(size+3)). DONE is cycle N+1.
  - size = 2: DONE at cycle 25.
  - size = 4: DONE at cycle 121.
- out_busy is high in cycles 1..N+1.
- A new in_start is accepted no earlier than cycle N+2.
- Read data dependency: the data for a read issued in cycle t is sampled from in_rf_data at the end of cycle t+1.

## Structure
- A shared package, coproc_pkg, holds:
  - the state encoding;
  - the type codes TYPE_CELL, TYPE_ROW and TYPE_COL;
  - the matrix codes MAT_A, MAT_B and MAT_C.
- The register file uses the same constants from this package.
- Sub-module mac_unit (cell_width)
  - Inputs: clear, enable, a, b. Output: acc.
  - acc ← 0 on clear; acc ← acc + a*b on enable; both operations are mod 2^cell_width.
  - Asynchronous active-low reset.
- The controller holds the FSM, the i/j/n counters, the row and column buffers, and the output decode.

## Test plan
- Basic multiply: size = 2, A = [[1,2],[3,4]], B = [[5,6],[7,8]], pulse in_start.
  - C = [[19,22],[43,50]].
  - out_done is high only in cycle 25; out_busy is high in cycles 1–25.
- Bus sequence for the first cell, with size = 2:
  - cycle 1: read, type 01, select 00, address 0;
  - cycle 3: read, type 10, select 01, address 0;
  - cycle 7: write, type 00, select 10, address 0, data 19.
- Identity: size = 4, A = I, B = cells 0..15 → C equals B after 121 cycles.
- Wrap-around: cell_width = 32, A[0][0] = 0xFFFFFFFF, B[0][0] = 2, all other cells 0 → C[0][0] = 0xFFFFFFFE.
- Start while busy: pulse in_start at cycles 5 and 25 → only one done pulse, and C is unchanged.
- Reset mid-operation: with size = 2, drop in_reset in cycle 10 (MAC for cell (0,1)).
  - All outputs are 0 immediately, and C[0][0] = 19 is retained.
  - After release, a new in_start produces the correct C in 25 cycles.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared coprocessor constants: sequencer state encoding plus the register-file
// access type and matrix select codes, used by the controller and register file.
package coproc_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      READ_ROW  = 3'd1,
      LATCH_ROW = 3'd2,
      READ_COL  = 3'd3,
      LATCH_COL = 3'd4,
      MAC       = 3'd5,
      WRITE     = 3'd6,
      DONE      = 3'd7
   } state_t;

   // Register-file access shape.
   localparam logic [1:0] TYPE_CELL = 2'b00;
   localparam logic [1:0] TYPE_ROW  = 2'b01;
   localparam logic [1:0] TYPE_COL  = 2'b10;

   // Register-file matrix select.
   localparam logic [1:0] MAT_A = 2'b00;
   localparam logic [1:0] MAT_B = 2'b01;
   localparam logic [1:0] MAT_C = 2'b10;

   // Width of a counter that indexes 0..count-1 (never narrower than one bit).
   function automatic int counter_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/matmul_controller_if.sv
// Command and register-file bus of the matmul controller. The master side is
// the controller; the slave side is the command logic plus register file.
// Handshake: in_start is a level sampled only while the controller is idle;
// a register-file read issued in cycle t returns data on in_rf_data that is
// sampled at the end of cycle t+1; a write completes in the cycle write_en is high.
interface matmul_controller_if #(
   parameter int size          = 4,
   parameter int cell_width    = 32,
   parameter int address_width = $clog2(size * size),
   parameter int width         = cell_width * size
);
   import coproc_pkg::*;

   logic                     in_start;
   logic                     out_busy;
   logic                     out_done;
   logic [address_width-1:0] out_rf_address;
   logic [1:0]               out_rf_type;
   logic [1:0]               out_rf_select_matrix;
   logic                     out_rf_read_en;
   logic                     out_rf_write_en;
   logic [width-1:0]         out_rf_data;
   logic [width-1:0]         in_rf_data;
   state_t                   state;

   modport master (
      input  in_start,
      input  in_rf_data,
      output out_busy,
      output out_done,
      output out_rf_address,
      output out_rf_type,
      output out_rf_select_matrix,
      output out_rf_read_en,
      output out_rf_write_en,
      output out_rf_data,
      output state
   );

   modport slave (
      output in_start,
      output in_rf_data,
      input  out_busy,
      input  out_done,
      input  out_rf_address,
      input  out_rf_type,
      input  out_rf_select_matrix,
      input  out_rf_read_en,
      input  out_rf_write_en,
      input  out_rf_data,
      input  state
   );

endinterface

// File: rtl/matmul_controller_mac_unit.sv
// Multiply-accumulate unit: acc accumulates a*b modulo 2^cell_width.
// clear has priority over enable.
module mac_unit #(
   parameter int cell_width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [cell_width-1:0] a,
   input  logic [cell_width-1:0] b,
   output logic [cell_width-1:0] acc
);

   // Accumulator register; products and sums wrap at cell_width bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + a * b;
      end
   end

endmodule

// File: rtl/matmul_controller.sv
// Matrix-multiply sequencer: computes C = A x B over the three-matrix register
// file. Each row of A is read once and reused for every column of B; each dot
// product runs through the mac_unit, then the result cell is written to C.
module matmul_controller
   import coproc_pkg::*;
#(
   parameter int size          = 4,
   parameter int address_width = $clog2(size * size),
   parameter int cell_width    = 32,
   parameter int width         = cell_width * size
) (
   input logic                in_clk,
   input logic                in_reset,
   matmul_controller_if.master bus
);

   localparam int cnt_width = counter_width(size);
   localparam logic [cnt_width-1:0] last_index = cnt_width'(size - 1);
   localparam logic [cnt_width-1:0] one_index  = cnt_width'(1);

   state_t                   state;
   logic [cnt_width-1:0]     i;
   logic [cnt_width-1:0]     j;
   logic [cnt_width-1:0]     n;
   logic [cell_width-1:0]    row_buf [size];
   logic [cell_width-1:0]    col_buf [size];
   logic [cell_width-1:0]    rd_cells [size];

   logic                     busy;
   logic                     done;
   logic                     read_en;
   logic                     write_en;
   logic [1:0]               rf_type;
   logic [1:0]               rf_select;
   logic [address_width-1:0] rf_address;

   logic                     mac_clear;
   logic                     mac_enable;
   logic [cell_width-1:0]    mac_a;
   logic [cell_width-1:0]    mac_b;
   logic [cell_width-1:0]    acc;

   logic [address_width-1:0] row_base;
   logic [address_width-1:0] next_row_base;
   logic [address_width-1:0] col_address;
   logic [address_width-1:0] next_col_address;
   logic [address_width-1:0] cell_address;

   // Split the read bus into cells; cell k sits at bits [k*cell_width +: cell_width].
   for (genvar g = 0; g < size; g++) begin : g_split
      assign rd_cells[g] = bus.in_rf_data[g*cell_width +: cell_width];
   end

   // Address arithmetic for the current and next accesses.
   assign row_base         = address_width'(i) * address_width'(size);
   assign next_row_base    = row_base + address_width'(size);
   assign col_address      = address_width'(j);
   assign next_col_address = address_width'(j) + address_width'(1);
   assign cell_address     = row_base + address_width'(j);

   // Accumulator control: cleared on start and when a new column is latched,
   // advanced one product per MAC cycle.
   always_comb begin
      mac_clear  = (state == LATCH_COL) || ((state == IDLE) && bus.in_start);
      mac_enable = (state == MAC);
      mac_a      = row_buf[n];
      mac_b      = col_buf[n];
   end

   mac_unit #(
      .cell_width(cell_width)
   ) u_mac (
      .clk   (in_clk),
      .rst_n (in_reset),
      .clear (mac_clear),
      .enable(mac_enable),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (acc)
   );

   // Sequencer FSM. Bus outputs are registered alongside the state so that
   // they describe the state being entered.
   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state      <= IDLE;
         i          <= '0;
         j          <= '0;
         n          <= '0;
         row_buf    <= '{default: '0};
         col_buf    <= '{default: '0};
         busy       <= 1'b0;
         done       <= 1'b0;
         read_en    <= 1'b0;
         write_en   <= 1'b0;
         rf_type    <= TYPE_CELL;
         rf_select  <= MAT_A;
         rf_address <= '0;
      end else begin
         read_en    <= 1'b0;
         write_en   <= 1'b0;
         done       <= 1'b0;
         rf_type    <= TYPE_CELL;
         rf_select  <= MAT_A;
         rf_address <= '0;
         case (state)
            IDLE: begin
               if (bus.in_start) begin
                  state      <= READ_ROW;
                  i          <= '0;
                  j          <= '0;
                  n          <= '0;
                  busy       <= 1'b1;
                  read_en    <= 1'b1;
                  rf_type    <= TYPE_ROW;
                  rf_select  <= MAT_A;
                  rf_address <= '0;
               end
            end
            READ_ROW: begin
               state <= LATCH_ROW;
            end
            LATCH_ROW: begin
               row_buf    <= rd_cells;
               state      <= READ_COL;
               read_en    <= 1'b1;
               rf_type    <= TYPE_COL;
               rf_select  <= MAT_B;
               rf_address <= col_address;
            end
            READ_COL: begin
               state <= LATCH_COL;
            end
            LATCH_COL: begin
               col_buf <= rd_cells;
               n       <= '0;
               state   <= MAC;
            end
            MAC: begin
               if (n == last_index) begin
                  state      <= WRITE;
                  write_en   <= 1'b1;
                  rf_type    <= TYPE_CELL;
                  rf_select  <= MAT_C;
                  rf_address <= cell_address;
               end else begin
                  n <= n + one_index;
               end
            end
            WRITE: begin
               if (j != last_index) begin
                  j          <= j + one_index;
                  state      <= READ_COL;
                  read_en    <= 1'b1;
                  rf_type    <= TYPE_COL;
                  rf_select  <= MAT_B;
                  rf_address <= next_col_address;
               end else if (i != last_index) begin
                  j          <= '0;
                  i          <= i + one_index;
                  state      <= READ_ROW;
                  read_en    <= 1'b1;
                  rf_type    <= TYPE_ROW;
                  rf_select  <= MAT_A;
                  rf_address <= next_row_base;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Bus drive. Write data is the settled accumulator, zero-extended, and only
   // while a write is presented.
   assign bus.out_busy             = busy;
   assign bus.out_done             = done;
   assign bus.out_rf_address       = rf_address;
   assign bus.out_rf_type          = rf_type;
   assign bus.out_rf_select_matrix = rf_select;
   assign bus.out_rf_read_en       = read_en;
   assign bus.out_rf_write_en      = write_en;
   assign bus.out_rf_data          = write_en ? width'(acc) : '0;
   assign bus.state                = state;

endmodule
